// File: rtl/lshift_reg_pkg.sv
// Shared constants and helpers for lshift_reg and other walking-bit generators.
package lshift_reg_pkg;

    localparam int unsigned LSHIFT_REG_W_DEFAULT = 8;
    // Widest register the shared rotl helper supports.
    localparam int unsigned LSHIFT_REG_W_MAX = 64;
    // Every bit of the register resets to this value (all-zero contents).
    localparam logic LSHIFT_REG_RST_BIT = 1'b0;

    // Rotate the low w bits of v left by one; bits at and above w come back as 0.
    function automatic logic [LSHIFT_REG_W_MAX-1:0] rotl(
        input logic [LSHIFT_REG_W_MAX-1:0] v,
        input int unsigned w
    );
        logic [LSHIFT_REG_W_MAX-1:0] r;
        r = '0;
        for (int unsigned i = 0; i < LSHIFT_REG_W_MAX; i++) begin
            if (i < w) begin
                r[i] = (i == 0) ? v[w-1] : v[i-1];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/lshift_reg.sv
// Parallel-loadable left-rotate register (walking-bit / pattern generator).
// Optional registered wrap flag when LSHIFT_REG_WRAP_FLAG_EN is defined.
module lshift_reg
    import lshift_reg_pkg::*;
#(
    parameter int unsigned WIDTH = LSHIFT_REG_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [WIDTH-1:0] load_val,
    input  logic             load_en,
    output logic [WIDTH-1:0] op
`ifdef LSHIFT_REG_WRAP_FLAG_EN
    ,
    output logic             wrap
`endif
);

    if (WIDTH < 2 || WIDTH > LSHIFT_REG_W_MAX) begin : g_bad_width
        $error("lshift_reg: WIDTH out of range");
    end

    logic [LSHIFT_REG_W_MAX-1:0] op_wide;
    logic [LSHIFT_REG_W_MAX-1:0] rot_wide;
    logic [WIDTH-1:0]            rot;
    logic                        unused_rot_bits;

    assign op_wide         = LSHIFT_REG_W_MAX'(op);
    assign rot_wide        = rotl(op_wide, WIDTH);
    assign rot             = rot_wide[WIDTH-1:0];
    assign unused_rot_bits = &{1'b0, rot_wide};

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            op <= {WIDTH{LSHIFT_REG_RST_BIT}};
        end else if (load_en) begin
            op <= load_val;
        end else begin
            op <= rot;
        end
    end

`ifdef LSHIFT_REG_WRAP_FLAG_EN
    // Flags a 1 crossing from MSB to LSB on the rotate edge just taken.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wrap <= 1'b0;
        end else if (load_en) begin
            wrap <= 1'b0;
        end else begin
            wrap <= op[WIDTH-1];
        end
    end
`endif

endmodule

// File: tb/tb_lshift_reg.sv
// Randomized self-checking bench for lshift_reg against an arithmetic rotate model.
module tb_lshift_reg;

    localparam int W = 8;

    logic         clk;
    logic         rstn;
    logic [W-1:0] load_val;
    logic         load_en;
    logic [W-1:0] op;
`ifdef LSHIFT_REG_WRAP_FLAG_EN
    logic         wrap;
`endif

    lshift_reg #(.WIDTH(W)) dut (
        .clk      (clk),
        .rstn     (rstn),
        .load_val (load_val),
        .load_en  (load_en),
        .op       (op)
`ifdef LSHIFT_REG_WRAP_FLAG_EN
        ,
        .wrap     (wrap)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    longint unsigned model_v    = 0;
    logic            model_wrap = 1'b0;
    logic [W-1:0]    exp_q[$];

    // Rotate left by one using arithmetic on the numeric value.
    function automatic longint unsigned model_rotl(input longint unsigned v);
        longint unsigned span;
        span = 64'd1 << W;
        return ((v * 2) % span) + (v / (span / 2));
    endfunction

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_outputs(input string tag);
        check(tag, op, exp_q.pop_front());
`ifdef LSHIFT_REG_WRAP_FLAG_EN
        check({tag, "_wrap"}, W'(wrap), W'(model_wrap));
`endif
    endtask

    // Called just after a falling edge; applies inputs for one rising edge.
    task automatic drive_cycle(input logic le, input logic [W-1:0] lv, input string tag);
        load_en  = le;
        load_val = lv;
        @(posedge clk);
        if (rstn) begin
            if (le) begin
                model_v    = longint'(lv);
                model_wrap = 1'b0;
            end else begin
                model_wrap = (model_v >= (64'd1 << (W - 1)));
                model_v    = model_rotl(model_v);
            end
        end
        exp_q.push_back(W'(model_v));
        #1;
        check_outputs(tag);
        @(negedge clk);
    endtask

    // Pulse reset between edges and check the clear happens before any edge.
    task automatic async_reset(input string tag);
        #2;
        rstn       = 1'b0;
        model_v    = 0;
        model_wrap = 1'b0;
        exp_q.push_back(W'(model_v));
        #1;
        check_outputs(tag);
        @(negedge clk);
        rstn = 1'b1;
    endtask

    initial begin
        logic [W-1:0] walk;
        logic [W-1:0] prio_vals[3];

        rstn     = 1'b0;
        load_val = 8'h01;
        load_en  = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 2; i++) drive_cycle(1'b0, 8'h01, "reset_hold");
        rstn = 1'b1;
        for (int i = 0; i < 5; i++) drive_cycle(1'b0, 8'h00, "post_reset_zero");

        // Walking one, with an independent shift-constant cross-check.
        drive_cycle(1'b1, 8'h01, "load_01");
        walk = 8'h01;
        for (int i = 1; i <= 20; i++) begin
            drive_cycle(1'b0, $urandom, "walk");
            check("walk_const", op, walk << (i % 8));
        end

        drive_cycle(1'b1, 8'h81, "load_81");
        drive_cycle(1'b0, 8'h00, "rot_81_1");
        check("rot_81_const", op, 8'h03);
        drive_cycle(1'b0, 8'h00, "rot_81_2");
        drive_cycle(1'b0, 8'h00, "rot_81_3");
        check("rot_81_last", op, 8'h0C);

        drive_cycle(1'b1, 8'hFF, "load_ff");
        for (int i = 0; i < 4; i++) drive_cycle(1'b0, 8'h00, "hold_ff");
        check("ff_fixed", op, 8'hFF);

        prio_vals[0] = 8'hA5;
        prio_vals[1] = 8'h3C;
        prio_vals[2] = 8'h0F;
        for (int i = 0; i < 3; i++) begin
            drive_cycle(1'b1, prio_vals[i], "prio_load");
            check("prio_const", op, prio_vals[i]);
        end
        drive_cycle(1'b0, 8'hFF, "prio_rot");
        check("prio_rot_const", op, 8'h1E);

        drive_cycle(1'b1, 8'h10, "load_10");
        drive_cycle(1'b0, 8'h00, "to_20");
        drive_cycle(1'b0, 8'h00, "to_40");
        check("pre_async", op, 8'h40);
        async_reset("async_clear");
        for (int i = 0; i < 3; i++) drive_cycle(1'b0, 8'h00, "after_async");

`ifdef LSHIFT_REG_WRAP_FLAG_EN
        drive_cycle(1'b1, 8'h80, "wrap_load");
        check("wrap_after_load", W'(wrap), '0);
        drive_cycle(1'b0, 8'h00, "wrap_rot");
        check("wrap_pulse", W'(wrap), W'(1));
        drive_cycle(1'b0, 8'h00, "wrap_clear");
        check("wrap_drop", W'(wrap), '0);
`endif

        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 99) < 3) begin
                async_reset("rand_async");
            end else begin
                drive_cycle($urandom_range(0, 99) < 25, W'($urandom), "rand");
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
